pcie_tx_arbiter: RTL and testbench
==================================

Name: pcie_tx_arbiter

Overview:
- Packet-granular round-robin arbiter that shares the single PCIe core transmit AXI-stream between two TLP sources.
- Source 0 is the Ethernet-decap injection path; source 1 is the local config/completion path.
- Sits in the pcie_clk domain, between the TLP producers and the PCIe core s_axis_tx interface.
- Gates new grants on the core's transmit buffer availability, so a TLP is never started when the core cannot accept it.

Parameters:
- C_DATA_WIDTH, 64, stream data width in bits.
- KEEP_WIDTH, C_DATA_WIDTH/8, tkeep width.
- MIN_BUF_AV, 6'd2, minimum tx_buf_av value required to issue a grant.

Ports:
- pcie_clk  in  1  PCIe user clock; all logic on its rising edge.
- pcie_rst  in  1  asynchronous, active-high reset.
- tx_buf_av  in  6  PCIe core free transmit buffer count.
- s0_req  in  1  source 0 requests a packet slot.
- s0_ack  out  1  source 0 granted; high for the whole packet.
- s0_tvalid / s0_tready / s0_tlast  in/out/in  1 each  source 0 stream handshake.
- s0_tkeep  in  KEEP_WIDTH  source 0 byte enables.
- s0_tdata  in  C_DATA_WIDTH  source 0 data.
- s0_tuser  in  4  source 0 tuser.
- s1_req, s1_ack, s1_tvalid, s1_tready, s1_tlast, s1_tkeep, s1_tdata, s1_tuser: same as source 0, for source 1.
- m_tvalid  out  1  to core.
- m_tready  in  1  from core.
- m_tlast  out  1  to core.
- m_tkeep  out  KEEP_WIDTH  to core.
- m_tdata  out  C_DATA_WIDTH  to core.
- m_tuser  out  4  to core.

Behaviour:
- One clock (pcie_clk); pcie_rst is asynchronous, active-high. Asserting it forces the state to IDLE and the round-robin pointer rr to 0 immediately, without waiting for a clock edge.
- Reset values:
  - s0_ack = 0, s1_ack = 0.
  - m_tvalid = 0, m_tlast = 0.
  - m_tkeep, m_tdata, m_tuser = 0.
  - s0_tready = 0, s1_tready = 0.
- States: IDLE, GNT0, GNT1 (registered).
- IDLE transitions, evaluated only when tx_buf_av >= MIN_BUF_AV:
  - only s0_req high -> GNT0.
  - only s1_req high -> GNT1.
  - both high -> GNT0 if rr = 0, else GNT1.
  - otherwise stay in IDLE.
- If tx_buf_av < MIN_BUF_AV, stay in IDLE regardless of requests.
- Latency: a req sampled high at edge N gives ack high and the first beat transferable in the cycle after edge N; no data beat is lost or duplicated.
- In GNTx:
  - sx_ack = 1.
  - m_t* = sx_t*, combinational pass-through.
  - sx_tready = m_tready.
  - The non-granted source sees tready = 0 and ack = 0.
- In IDLE: every m_t* output is 0 and both tready outputs are 0.
- GNTx -> IDLE on the beat where m_tvalid & m_tready & m_tlast are all high. On that edge rr <= ~x, so the other source has priority next.
- The bus always passes through one IDLE cycle between packets; no back-to-back grants.
- Deasserting sx_req mid-packet is ignored; the grant holds until tlast is accepted.
- tx_buf_av is checked only at grant time; it is not re-checked mid-packet.
- A single-beat packet (tlast on the first beat) returns to IDLE after one transfer.
- m_tvalid may stall for any number of cycles with no timeout; the grant is held.
- Reset mid-packet: grant and acks drop asynchronously, and the truncated TLP is not completed. Recovery is the source's responsibility.
- No tvalid is ever asserted on m_ without an active grant.

Optional Feature:
- Macro: PCIE_TX_ARB_STATS_EN.
- When defined, the block adds these output ports:
  - pkt_cnt0 (32 bits) and pkt_cnt1 (32 bits): count completed packets per source (tlast beats accepted). They wrap from 32'hFFFFFFFF to 0.
  - stall_cnt (32 bits): counts cycles spent in IDLE with any req high but tx_buf_av < MIN_BUF_AV. It saturates at 32'hFFFFFFFF.
- All three counters reset to 0 asynchronously.
- When not defined: these ports and their logic are absent, and arbitration behaviour is identical.

Test Plan:
- Only s0_req, 3-beat packet, m_tready = 1, tx_buf_av = 8 -> s0_ack high for 3 cycles starting the cycle after the req edge; m_tdata equals the s0 data beats; IDLE for one cycle afterwards; rr = 1.
- s0_req and s1_req both held continuously, 2-beat packets each -> grant order 0, 1, 0, 1; exactly one IDLE cycle between packets; never both acks high.
- tx_buf_av = 1 with s1_req high for 5 cycles, then tx_buf_av = 4 -> no grant during the 5 cycles; GNT1 the cycle after the change. With PCIE_TX_ARB_STATS_EN, stall_cnt = 5.
- Mid-packet m_tready low for 4 cycles on beat 2 -> s0_tready low for the same 4 cycles; no beat dropped; tlast is still accepted.
- pcie_rst pulsed asynchronously during beat 2 of a GNT1 packet -> s1_ack and m_tvalid go to 0 before the next edge; after release, state is IDLE and rr = 0.
- Single-beat packet from s1 followed by s0_req -> GNT1 for 1 cycle, then IDLE, then GNT0. With PCIE_TX_ARB_STATS_EN, pkt_cnt1 = 1 and pkt_cnt0 = 1.

Source files
------------

// File: rtl/pcie_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the PCIe core transmit stream between two TLP sources.
// Define PCIE_TX_ARB_STATS_EN to add per-source packet counters and a buffer-stall cycle counter.
`timescale 1ns/1ps

module pcie_tx_arbiter #(
  parameter int         C_DATA_WIDTH = 64,
  parameter int         KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter logic [5:0] MIN_BUF_AV   = 6'd2
) (
  input  logic                    pcie_clk,
  input  logic                    pcie_rst,
  input  logic [5:0]              tx_buf_av,

  input  logic                    s0_req,
  output logic                    s0_ack,
  input  logic                    s0_tvalid,
  output logic                    s0_tready,
  input  logic                    s0_tlast,
  input  logic [KEEP_WIDTH-1:0]   s0_tkeep,
  input  logic [C_DATA_WIDTH-1:0] s0_tdata,
  input  logic [3:0]              s0_tuser,

  input  logic                    s1_req,
  output logic                    s1_ack,
  input  logic                    s1_tvalid,
  output logic                    s1_tready,
  input  logic                    s1_tlast,
  input  logic [KEEP_WIDTH-1:0]   s1_tkeep,
  input  logic [C_DATA_WIDTH-1:0] s1_tdata,
  input  logic [3:0]              s1_tuser,

  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  output logic [KEEP_WIDTH-1:0]   m_tkeep,
  output logic [C_DATA_WIDTH-1:0] m_tdata,
  output logic [3:0]              m_tuser
`ifdef PCIE_TX_ARB_STATS_EN
  ,
  output logic [31:0]             pkt_cnt0,
  output logic [31:0]             pkt_cnt1,
  output logic [31:0]             stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state;
  logic   rr;
  logic   buf_ok;
  logic   s0_done;
  logic   s1_done;

  assign buf_ok  = (tx_buf_av >= MIN_BUF_AV);
  assign s0_done = (state == GNT0) && s0_tvalid && m_tready && s0_tlast;
  assign s1_done = (state == GNT1) && s1_tvalid && m_tready && s1_tlast;

  // rr points at the source that wins a tie; it flips to the other source when a packet finishes.
  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      state <= IDLE;
      rr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (buf_ok) begin
            if (s0_req && (!s1_req || !rr))
              state <= GNT0;
            else if (s1_req)
              state <= GNT1;
          end
        end
        GNT0: begin
          if (s0_done) begin
            state <= IDLE;
            rr    <= 1'b1;
          end
        end
        GNT1: begin
          if (s1_done) begin
            state <= IDLE;
            rr    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grant decode; the mux follows the registered state so a reset drops the grant immediately.
  always_comb begin
    s0_ack    = 1'b0;
    s1_ack    = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    m_tkeep   = '0;
    m_tdata   = '0;
    m_tuser   = '0;
    case (state)
      GNT0: begin
        s0_ack    = 1'b1;
        s0_tready = m_tready;
        m_tvalid  = s0_tvalid;
        m_tlast   = s0_tlast;
        m_tkeep   = s0_tkeep;
        m_tdata   = s0_tdata;
        m_tuser   = s0_tuser;
      end
      GNT1: begin
        s1_ack    = 1'b1;
        s1_tready = m_tready;
        m_tvalid  = s1_tvalid;
        m_tlast   = s1_tlast;
        m_tkeep   = s1_tkeep;
        m_tdata   = s1_tdata;
        m_tuser   = s1_tuser;
      end
      default: ;
    endcase
  end

`ifdef PCIE_TX_ARB_STATS_EN
  // Packet counters wrap; the stall counter saturates so long stalls stay visible.
  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      pkt_cnt0  <= '0;
      pkt_cnt1  <= '0;
      stall_cnt <= '0;
    end else begin
      if (s0_done)
        pkt_cnt0 <= pkt_cnt0 + 32'd1;
      if (s1_done)
        pkt_cnt1 <= pkt_cnt1 + 32'd1;
      if ((state == IDLE) && (s0_req || s1_req) && !buf_ok && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Directed self-checking bench for pcie_tx_arbiter; stats checks compile in with PCIE_TX_ARB_STATS_EN.
`timescale 1ns/1ps

module tb_pcie_tx_arbiter;

  localparam int DW = 64;
  localparam int KW = 8;

  logic          pcie_clk = 1'b0;
  logic          pcie_rst;
  logic [5:0]    tx_buf_av;
  logic          s0_req, s0_ack, s0_tvalid, s0_tready, s0_tlast;
  logic [KW-1:0] s0_tkeep;
  logic [DW-1:0] s0_tdata;
  logic [3:0]    s0_tuser;
  logic          s1_req, s1_ack, s1_tvalid, s1_tready, s1_tlast;
  logic [KW-1:0] s1_tkeep;
  logic [DW-1:0] s1_tdata;
  logic [3:0]    s1_tuser;
  logic          m_tvalid, m_tready, m_tlast;
  logic [KW-1:0] m_tkeep;
  logic [DW-1:0] m_tdata;
  logic [3:0]    m_tuser;
`ifdef PCIE_TX_ARB_STATS_EN
  logic [31:0]   pkt_cnt0, pkt_cnt1, stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int m_beats  = 0;

  pcie_tx_arbiter dut (
    .pcie_clk (pcie_clk),
    .pcie_rst (pcie_rst),
    .tx_buf_av(tx_buf_av),
    .s0_req   (s0_req),
    .s0_ack   (s0_ack),
    .s0_tvalid(s0_tvalid),
    .s0_tready(s0_tready),
    .s0_tlast (s0_tlast),
    .s0_tkeep (s0_tkeep),
    .s0_tdata (s0_tdata),
    .s0_tuser (s0_tuser),
    .s1_req   (s1_req),
    .s1_ack   (s1_ack),
    .s1_tvalid(s1_tvalid),
    .s1_tready(s1_tready),
    .s1_tlast (s1_tlast),
    .s1_tkeep (s1_tkeep),
    .s1_tdata (s1_tdata),
    .s1_tuser (s1_tuser),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tkeep  (m_tkeep),
    .m_tdata  (m_tdata),
    .m_tuser  (m_tuser)
`ifdef PCIE_TX_ARB_STATS_EN
    ,
    .pkt_cnt0 (pkt_cnt0),
    .pkt_cnt1 (pkt_cnt1),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 pcie_clk = ~pcie_clk;

  // Counts beats actually accepted on the core side.
  always @(posedge pcie_clk)
    if (m_tvalid && m_tready)
      m_beats <= m_beats + 1;

  task automatic step();
    @(posedge pcie_clk);
    #1;
  endtask

  task automatic clear_inputs();
    tx_buf_av = 6'd8;
    m_tready  = 1'b1;
    s0_req = 1'b0; s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tkeep = '0; s0_tdata = '0; s0_tuser = '0;
    s1_req = 1'b0; s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tkeep = '0; s1_tdata = '0; s1_tuser = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge pcie_clk);
    pcie_rst = 1'b1;
    @(negedge pcie_clk);
    pcie_rst = 1'b0;
    step();
  endtask

  // Outputs held at zero under reset even with every input active.
  task automatic test_reset();
    pcie_rst = 1'b1;
    clear_inputs();
    s0_req = 1'b1; s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tkeep = 8'hFF; s0_tdata = 64'hDEAD_BEEF_0000_0001; s0_tuser = 4'hF;
    s1_req = 1'b1; s1_tvalid = 1'b1; s1_tlast = 1'b1; s1_tkeep = 8'hFF; s1_tdata = 64'hDEAD_BEEF_0000_0002; s1_tuser = 4'hF;
    step();
    step();
    checks++;
    if ({s0_ack, s1_ack, m_tvalid, m_tlast, s0_tready, s1_tready} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000", {s0_ack, s1_ack, m_tvalid, m_tlast, s0_tready, s1_tready});
    end
    checks++;
    if (m_tdata !== 64'h0) begin
      failures++;
      $display("[TB] FAIL reset_tdata: got %h expected 0", m_tdata);
    end
    checks++;
    if ({m_tkeep, m_tuser} !== 12'h0) begin
      failures++;
      $display("[TB] FAIL reset_keep_user: got %h expected 000", {m_tkeep, m_tuser});
    end
`ifdef PCIE_TX_ARB_STATS_EN
    checks++;
    if ({pkt_cnt0, pkt_cnt1, stall_cnt} !== 96'h0) begin
      failures++;
      $display("[TB] FAIL reset_stats: got %h expected 0", {pkt_cnt0, pkt_cnt1, stall_cnt});
    end
`endif
    clear_inputs();
    pcie_rst = 1'b0;
    step();
  endtask

  // Lone source 0 sends a 3-beat packet; rr then favours source 1.
  task automatic test_single_source();
    do_reset();
    s0_req = 1'b1; s0_tvalid = 1'b1; s0_tlast = 1'b0; s0_tkeep = 8'hFF; s0_tdata = 64'h1000; s0_tuser = 4'h1;
    #1;
    checks++;
    if ({s0_ack, m_tvalid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL t1_pregrant: got %b expected 00", {s0_ack, m_tvalid});
    end
    step();
    s0_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({s0_ack, s1_ack, s0_tready, m_tvalid, m_tlast} !== {4'b1011, (i == 2)}) begin
        failures++;
        $display("[TB] FAIL t1_ctrl beat%0d: got %b expected %b", i, {s0_ack, s1_ack, s0_tready, m_tvalid, m_tlast}, {4'b1011, (i == 2)});
      end
      checks++;
      if (m_tdata !== 64'h1000 + 64'(i)) begin
        failures++;
        $display("[TB] FAIL t1_data beat%0d: got %h expected %h", i, m_tdata, 64'h1000 + 64'(i));
      end
      step();
      if (i < 2) begin
        s0_tdata = 64'h1000 + 64'(i + 1);
        s0_tlast = (i == 1);
      end else begin
        s0_tvalid = 1'b0;
        s0_tlast  = 1'b0;
      end
    end
    #1;
    checks++;
    if ({s0_ack, m_tvalid} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL t1_idle: got %b expected 00", {s0_ack, m_tvalid});
    end
    checks++;
    if ({m_tkeep, m_tuser} !== 12'h0) begin
      failures++;
      $display("[TB] FAIL t1_idle_keep: got %h expected 000", {m_tkeep, m_tuser});
    end
    s0_req = 1'b1; s0_tvalid = 1'b1; s0_tdata = 64'hA0;
    s1_req = 1'b1; s1_tvalid = 1'b1; s1_tdata = 64'hB0;
    step();
    #1;
    checks++;
    if ({s0_ack, s1_ack} !== 2'b01 || m_tdata !== 64'hB0) begin
      failures++;
      $display("[TB] FAIL t1_rr_next: got acks=%b data=%h expected acks=01 data=b0", {s0_ack, s1_ack}, m_tdata);
    end
  endtask

  // Both sources request continuously with 2-beat packets; grants alternate with one IDLE gap.
  task automatic test_alternate();
    int exp_src[12] = '{0, 0, 2, 1, 1, 2, 0, 0, 2, 1, 1, 2};
    int b0, b1, p0, p1;
    logic hs0, hs1;
    logic [DW-1:0] exp_data;
    do_reset();
    b0 = 0; b1 = 0; p0 = 0; p1 = 0;
    s0_req = 1'b1; s0_tvalid = 1'b1;
    s1_req = 1'b1; s1_tvalid = 1'b1;
    s0_tdata = 64'h0;     s0_tlast = 1'b0;
    s1_tdata = 64'h10000; s1_tlast = 1'b0;
    #1;
    for (int c = 0; c < 12; c++) begin
      hs0 = s0_tvalid && s0_tready;
      hs1 = s1_tvalid && s1_tready;
      step();
      if (hs0) begin
        if (b0 == 1) begin b0 = 0; p0++; end else b0 = 1;
      end
      if (hs1) begin
        if (b1 == 1) begin b1 = 0; p1++; end else b1 = 1;
      end
      s0_tdata = 64'(p0 * 256 + b0);
      s0_tlast = (b0 == 1);
      s1_tdata = 64'(65536 + p1 * 256 + b1);
      s1_tlast = (b1 == 1);
      #1;
      checks++;
      if ({s0_ack, s1_ack, m_tvalid} !== {(exp_src[c] == 0), (exp_src[c] == 1), (exp_src[c] != 2)}) begin
        failures++;
        $display("[TB] FAIL t2_grant cyc%0d: got %b expected src %0d", c, {s0_ack, s1_ack, m_tvalid}, exp_src[c]);
      end
      if (exp_src[c] != 2) begin
        exp_data = 64'(exp_src[c] * 65536 + (c / 6) * 256 + (c % 3));
        checks++;
        if (m_tdata !== exp_data) begin
          failures++;
          $display("[TB] FAIL t2_data cyc%0d: got %h expected %h", c, m_tdata, exp_data);
        end
      end
    end
  endtask

  // Buffer below threshold blocks the grant until it recovers.
  task automatic test_buf_stall();
    do_reset();
    tx_buf_av = 6'd1;
    s1_req = 1'b1; s1_tvalid = 1'b1; s1_tlast = 1'b1; s1_tdata = 64'h33;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({s1_ack, m_tvalid} !== 2'b00) begin
        failures++;
        $display("[TB] FAIL t3_nogrant cyc%0d: got %b expected 00", i, {s1_ack, m_tvalid});
      end
    end
    tx_buf_av = 6'd4;
`ifdef PCIE_TX_ARB_STATS_EN
    #1;
    checks++;
    if (stall_cnt !== 32'd5) begin
      failures++;
      $display("[TB] FAIL t3_stall_cnt: got %0d expected 5", stall_cnt);
    end
`endif
    step();
    checks++;
    if ({s1_ack, m_tvalid} !== 2'b11 || m_tdata !== 64'h33) begin
      failures++;
      $display("[TB] FAIL t3_grant: got %b data=%h expected 11 data=33", {s1_ack, m_tvalid}, m_tdata);
    end
    s1_req = 1'b0;
    step();
    s1_tvalid = 1'b0;
    #1;
    checks++;
    if (s1_ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL t3_release: got %b expected 0", s1_ack);
    end
  endtask

  // Core backpressure for 4 cycles on beat 2; nothing dropped.
  task automatic test_backpressure();
    int start;
    do_reset();
    start = m_beats;
    s0_req = 1'b1; s0_tvalid = 1'b1; s0_tlast = 1'b0; s0_tdata = 64'h400;
    step();
    s0_req = 1'b0;
    step();
    s0_tdata = 64'h401;
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({s0_ack, s0_tready} !== 2'b10 || m_tdata !== 64'h401) begin
        failures++;
        $display("[TB] FAIL t4_stall cyc%0d: got %b data=%h expected 10 data=401", i, {s0_ack, s0_tready}, m_tdata);
      end
      step();
    end
    m_tready = 1'b1;
    #1;
    checks++;
    if (s0_tready !== 1'b1 || m_tdata !== 64'h401) begin
      failures++;
      $display("[TB] FAIL t4_resume: got %b data=%h expected 1 data=401", s0_tready, m_tdata);
    end
    step();
    s0_tdata = 64'h402; s0_tlast = 1'b1;
    step();
    s0_tvalid = 1'b0; s0_tlast = 1'b0;
    #1;
    checks++;
    if (s0_ack !== 1'b0 || (m_beats - start) !== 3) begin
      failures++;
      $display("[TB] FAIL t4_beats: got ack=%b beats=%0d expected ack=0 beats=3", s0_ack, m_beats - start);
    end
  endtask

  // Async reset in the middle of a GNT1 packet; rr was 1 beforehand and must clear.
  task automatic test_reset_midpacket();
    do_reset();
    s0_req = 1'b1; s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tdata = 64'h5;
    step();
    s0_req = 1'b0;
    step();
    s0_tvalid = 1'b0; s0_tlast = 1'b0;
    s1_req = 1'b1; s1_tvalid = 1'b1; s1_tlast = 1'b0; s1_tdata = 64'h50;
    step();
    s1_req = 1'b0;
    step();
    s1_tdata = 64'h51;
    #1;
    checks++;
    if ({s1_ack, m_tvalid} !== 2'b11 || m_tdata !== 64'h51) begin
      failures++;
      $display("[TB] FAIL t5_beat2: got %b data=%h expected 11 data=51", {s1_ack, m_tvalid}, m_tdata);
    end
    #2;
    pcie_rst = 1'b1;
    #1;
    checks++;
    if ({s1_ack, m_tvalid, s1_tready} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL t5_async_drop: got %b expected 000", {s1_ack, m_tvalid, s1_tready});
    end
    s1_tvalid = 1'b0;
    step();
    pcie_rst = 1'b0;
    s0_req = 1'b1; s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tdata = 64'h60;
    s1_req = 1'b1; s1_tvalid = 1'b1; s1_tlast = 1'b1; s1_tdata = 64'h61;
    #1;
    checks++;
    if ({s0_ack, s1_ack} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL t5_idle_after: got %b expected 00", {s0_ack, s1_ack});
    end
    step();
    checks++;
    if ({s0_ack, s1_ack} !== 2'b10 || m_tdata !== 64'h60) begin
      failures++;
      $display("[TB] FAIL t5_rr_cleared: got %b data=%h expected 10 data=60", {s0_ack, s1_ack}, m_tdata);
    end
  endtask

  // Single-beat packet from s1, then s0 gets the bus after one IDLE cycle.
  task automatic test_single_beat();
    do_reset();
    s1_req = 1'b1; s1_tvalid = 1'b1; s1_tlast = 1'b1; s1_tdata = 64'h70;
    step();
    checks++;
    if ({s0_ack, s1_ack, m_tlast} !== 3'b011) begin
      failures++;
      $display("[TB] FAIL t6_gnt1: got %b expected 011", {s0_ack, s1_ack, m_tlast});
    end
    s1_req = 1'b0;
    s0_req = 1'b1; s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tdata = 64'h71;
    step();
    s1_tvalid = 1'b0; s1_tlast = 1'b0;
    #1;
    checks++;
    if ({s0_ack, s1_ack, m_tvalid} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL t6_idle: got %b expected 000", {s0_ack, s1_ack, m_tvalid});
    end
    step();
    checks++;
    if ({s0_ack, s1_ack} !== 2'b10 || m_tdata !== 64'h71) begin
      failures++;
      $display("[TB] FAIL t6_gnt0: got %b data=%h expected 10 data=71", {s0_ack, s1_ack}, m_tdata);
    end
    s0_req = 1'b0;
    step();
    s0_tvalid = 1'b0; s0_tlast = 1'b0;
    #1;
    checks++;
    if (s0_ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL t6_done: got %b expected 0", s0_ack);
    end
`ifdef PCIE_TX_ARB_STATS_EN
    checks++;
    if (pkt_cnt0 !== 32'd1 || pkt_cnt1 !== 32'd1) begin
      failures++;
      $display("[TB] FAIL t6_pkt_cnt: got %0d/%0d expected 1/1", pkt_cnt0, pkt_cnt1);
    end
`endif
  endtask

  initial begin
    pcie_rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_source();
    test_alternate();
    test_buf_stall();
    test_backpressure();
    test_reset_midpacket();
    test_single_beat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
